// File: rtl/token_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : token_decoder_pkg
// Purpose : Shared types and defaults for the token decoder. It holds the
//           FSM state enumeration and the default widths used by the decoder.
//           The decoder sizes its seek counter (skip) from DATA_WIDTH,
//           because a code is DATA_WIDTH bits wide and skip is code-1.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package token_decoder_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 4;
   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_RD_CODE   = 4'd1,
      S_EVAL_CODE = 4'd2,
      S_SEEK_RD   = 4'd3,
      S_SEEK_EVAL = 4'd4,
      S_COPY_RD   = 4'd5,
      S_COPY_EVAL = 4'd6,
      S_TERM      = 4'd7,
      S_DONE      = 4'd8,
      S_ERR       = 4'd9
   } state_t;

endpackage : token_decoder_pkg
`default_nettype wire

// File: rtl/token_decoder.sv
`default_nettype none
// ============================================================================
// Module  : token_decoder
// Purpose : Walks a zero-terminated stream of token codes. Each code k >= 1 is
//           resolved to vocabulary entry k-1, which is a zero-terminated
//           string. The decoder copies that string's characters into the
//           output RAM. After the last code it writes one final zero
//           terminator. All three RAMs are synchronous and have a one-cycle
//           read latency.
// Ports   : clk, rst_n (sync, active-low), cs (start level)
//           code_addr/code_din    - code RAM read port
//           vocab_addr/vocab_din  - vocabulary RAM read port
//           out_we/out_addr/out_dout - output RAM write port
//           char_count            - characters written this run, terminator
//                                   excluded
//           done / err            - normal completion / abort status
// Revision: 1.0 - initial release
// ============================================================================
module token_decoder
   import token_decoder_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   output logic [ADDR_WIDTH-1:0] code_addr,
   input  logic [DATA_WIDTH-1:0] code_din,
   output logic [ADDR_WIDTH-1:0] vocab_addr,
   input  logic [DATA_WIDTH-1:0] vocab_din,
   output logic                  out_we,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_dout,
   output logic [ADDR_WIDTH-1:0] char_count,
   output logic                  done,
   output logic                  err
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   state_t                state;
   logic [DATA_WIDTH-1:0] skip;      // entries still to pass over while seeking
   logic                  at_start;  // next vocab char is the first of an entry

   // The top output slot is kept for the final terminator.
   logic out_full;
   logic vocab_end;
   assign out_full  = (out_addr == ADDR_MAX);
   assign vocab_end = (vocab_addr == ADDR_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         code_addr  <= '0;
         vocab_addr <= '0;
         out_we     <= 1'b0;
         out_addr   <= '0;
         out_dout   <= '0;
         char_count <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         skip       <= '0;
         at_start   <= 1'b0;
      end else begin
         out_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cs) begin
                  code_addr  <= '0;
                  out_addr   <= '0;
                  char_count <= '0;
                  done       <= 1'b0;
                  err        <= 1'b0;
                  state      <= S_RD_CODE;
               end
            end

            S_RD_CODE: state <= S_EVAL_CODE;

            S_EVAL_CODE: begin
               if (code_din == '0) begin
                  state <= S_TERM;
               end else begin
                  skip       <= code_din - 1'b1;
                  vocab_addr <= '0;
                  at_start   <= 1'b1;
                  state      <= S_SEEK_RD;
               end
            end

            S_SEEK_RD: state <= S_SEEK_EVAL;

            S_SEEK_EVAL: begin
               if (at_start && (vocab_din == '0)) begin
                  // An empty entry marks the vocab end, so the code is out of range.
                  err   <= 1'b1;
                  state <= S_ERR;
               end else if (skip == '0) begin
                  // First character of the selected entry.
                  if (out_full || vocab_end) begin
                     err   <= 1'b1;
                     state <= S_ERR;
                  end else begin
                     out_we     <= 1'b1;
                     out_dout   <= vocab_din;
                     vocab_addr <= vocab_addr + 1'b1;
                     state      <= S_COPY_RD;
                  end
               end else if (vocab_end) begin
                  err   <= 1'b1;
                  state <= S_ERR;
               end else begin
                  if (vocab_din == '0) begin
                     skip     <= skip - 1'b1;
                     at_start <= 1'b1;
                  end else begin
                     at_start <= 1'b0;
                  end
                  vocab_addr <= vocab_addr + 1'b1;
                  state      <= S_SEEK_RD;
               end
            end

            // COPY_RD always follows a character write. The address advance
            // is done here so it lines up with the write strobe.
            S_COPY_RD: begin
               out_addr   <= out_addr + 1'b1;
               char_count <= char_count + 1'b1;
               state      <= S_COPY_EVAL;
            end

            S_COPY_EVAL: begin
               if (vocab_din == '0) begin
                  // When the code RAM is exhausted, the stream ends implicitly.
                  if (code_addr == ADDR_MAX) begin
                     state <= S_TERM;
                  end else begin
                     code_addr <= code_addr + 1'b1;
                     state     <= S_RD_CODE;
                  end
               end else if (out_full || vocab_end) begin
                  err   <= 1'b1;
                  state <= S_ERR;
               end else begin
                  out_we     <= 1'b1;
                  out_dout   <= vocab_din;
                  vocab_addr <= vocab_addr + 1'b1;
                  state      <= S_COPY_RD;
               end
            end

            S_TERM: begin
               out_we   <= 1'b1;
               out_dout <= '0;
               done     <= 1'b1;
               state    <= S_DONE;
            end

            S_DONE, S_ERR: begin
               if (!cs) state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule : token_decoder
`default_nettype wire
